// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings, fetch FSM states, reset PC.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_REG = 2'd1;
  localparam logic [1:0] PCSEL_BR  = 2'd2;
  localparam logic [1:0] PCSEL_JMP = 2'd3;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, register, branch or jump target.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] ir,
  input  logic [1:0]      sel,
  input  logic            bc,
  input  logic [XLEN-1:0] rs_val,
  output logic [XLEN-1:0] next_pc,
  output logic            misalign_raw
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;

  always_comb begin
    pc4          = pc + 32'd4;
    br_off       = {{14{ir[15]}}, ir[15:0], 2'b00};
    next_pc      = pc4;
    misalign_raw = 1'b0;
    case (sel)
      PCSEL_SEQ: next_pc = pc4;
      PCSEL_REG: begin
        next_pc      = {rs_val[31:2], 2'b00};
        misalign_raw = |rs_val[1:0];
      end
      PCSEL_BR:  next_pc = bc ? (pc4 + br_off) : pc4;
      PCSEL_JMP: next_pc = {pc4[31:28], ir[25:0], 2'b00};
      default:   next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Multi-cycle fetch stage: owns PC and IR, fetches over req/ack, commits next PC
// when execute reports completion.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             halt,
  output logic [31:0]      Instruction,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic [1:0]       PC_MUX_SEL,
  input  logic             bc,
  input  logic [31:0]      rs_val,
  output logic [31:0]      pc_out,
  output logic [31:0]      link_addr,
  output logic             misalign,
  output logic [CNT_W-1:0] retired
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      next_pc;
  logic             misalign_raw;

  next_pc_calc u_next_pc_calc (
    .pc           (pc_q),
    .ir           (ir_q),
    .sel          (PC_MUX_SEL),
    .bc           (bc),
    .rs_val       (rs_val),
    .next_pc      (next_pc),
    .misalign_raw (misalign_raw)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      retired_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      retired_q  <= retired_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state and request logic; request drops immediately under halt or reset
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    misalign_d = 1'b0;
    imem_req   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = !halt && !reset;
        if (!halt && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          pc_d       = next_pc;
          retired_d  = retired_q + CNT_W'(1);
          misalign_d = misalign_raw;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign link_addr   = pc_q + 32'd4;
  assign Instruction = ir_q;
  assign instr_valid = (state_q == ISSUE);
  assign misalign    = misalign_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a behavioural
// model of PC, IR and retired count.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        halt;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  pc_mux_sel;
  logic        bc;
  logic [31:0] rs_val;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic        misalign;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic [31:0] exp_ret;

  instruction_fetch #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .halt        (halt),
    .Instruction (instruction),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .PC_MUX_SEL  (pc_mux_sel),
    .bc          (bc),
    .rs_val      (rs_val),
    .pc_out      (pc_out),
    .link_addr   (link_addr),
    .misalign    (misalign),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule computed with plain arithmetic
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ir,
                                           input logic [1:0] sel, input logic b,
                                           input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = int'($signed(ir[15:0]));
    case (sel)
      2'd0:    return seq;
      2'd1:    return rs - (rs % 32'd4);
      2'd2:    return b ? seq + 32'(off * 4) : seq;
      default: return (seq & 32'hF000_0000) + (ir & 32'h03FF_FFFF) * 32'd4;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1; halt = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    #1;
    chk("req_during_reset", 32'(imem_req), 32'd0);
    step();
    reset = 1'b0;
    exp_pc = RST_PC; exp_ir = '0; exp_ret = '0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_ir", instruction, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_addr", imem_addr, exp_pc);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
  endtask

  // Optional halt cycles, then lat wait cycles, then ack with word w
  task automatic fetch(input logic [31:0] w, input int lat, input int nhalt);
    for (int i = 0; i < nhalt; i++) begin
      halt = 1'b1;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      exec_done = 1'($urandom_range(0, 1));
      #1;
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_addr", imem_addr, exp_pc);
      step();
    end
    halt = 1'b0; imem_ack = 1'b0;
    for (int i = 0; i < lat; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      pc_mux_sel = 2'($urandom_range(0, 3));
      #1;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", imem_addr, exp_pc);
      step();
    end
    exec_done = 1'b0;
    imem_ack = 1'b1; imem_rdata = w;
    #1;
    chk("ack_req", 32'(imem_req), 32'd1);
    chk("ack_addr", imem_addr, exp_pc);
    step();
    imem_ack = 1'b0; imem_rdata = $urandom;
    exp_ir = w;
    #1;
    chk("issue_valid", 32'(instr_valid), 32'd1);
    chk("issue_ir", instruction, exp_ir);
    chk("issue_pc", pc_out, exp_pc);
    chk("issue_link", link_addr, exp_pc + 32'd4);
    chk("issue_req", 32'(imem_req), 32'd0);
    chk("misalign_clear", 32'(misalign), 32'd0);
  endtask

  task automatic exec(input logic [1:0] sel, input logic b, input logic [31:0] rs);
    logic [31:0] nxt;
    logic        mis;
    halt = 1'b0; imem_ack = 1'b0;
    exec_done = 1'b1; pc_mux_sel = sel; bc = b; rs_val = rs;
    nxt = ref_next(exp_pc, exp_ir, sel, b, rs);
    mis = (sel == 2'd1) && (rs % 32'd4 != 0);
    step();
    exec_done = 1'b0;
    pc_mux_sel = 2'($urandom_range(0, 3)); bc = 1'($urandom_range(0, 1)); rs_val = $urandom;
    exp_pc = nxt;
    exp_ret = exp_ret + 32'd1;
    #1;
    chk("commit_retired", retired, exp_ret);
    chk("commit_misalign", 32'(misalign), 32'(mis));
    chk("commit_valid", 32'(instr_valid), 32'd0);
    chk("commit_addr", imem_addr, exp_pc);
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; pc_mux_sel = 2'd0; bc = 1'b0; rs_val = '0;
    step();
    do_reset();

    // Sequential fetches from reset
    for (int k = 0; k < 3; k++) begin
      fetch(32'hA000_0000 + 32'(k), 2, 0);
      exec(2'd0, 1'b0, 32'd0);
    end
    chk("t1_addr", imem_addr, 32'd12);
    chk("t1_retired", retired, 32'd3);

    // Taken and untaken backward branch from 0x100
    fetch(32'h0000_0001, 0, 0);
    exec(2'd1, 1'b0, 32'h0000_0100);
    fetch(32'h1000_FFFE, 1, 0);
    exec(2'd2, 1'b1, 32'd0);
    chk("t2_taken", imem_addr, 32'h0000_00FC);
    fetch(32'h0000_0002, 0, 0);
    exec(2'd1, 1'b0, 32'h0000_0100);
    fetch(32'h1000_FFFE, 0, 0);
    exec(2'd2, 1'b0, 32'd0);
    chk("t2_untaken", imem_addr, 32'h0000_0104);

    // Jump keeping upper PC nibble
    fetch(32'h0000_0003, 0, 0);
    exec(2'd1, 1'b0, 32'h1000_0010);
    fetch(32'h0800_0040, 0, 0);
    exec(2'd3, 1'b0, 32'd0);
    chk("t3_jump", imem_addr, 32'h1000_0100);

    // Misaligned register target; pulse clears next cycle
    fetch(32'h0000_0004, 0, 0);
    exec(2'd1, 1'b0, 32'h0000_2003);
    chk("t4_addr", imem_addr, 32'h0000_2000);
    chk("t4_pulse", 32'(misalign), 32'd1);
    step();
    chk("t4_pulse_end", 32'(misalign), 32'd0);

    // Halt for five cycles, then resume with the same address
    fetch(32'h0000_0005, 0, 5);
    exec(2'd0, 1'b0, 32'd0);

    // PC wrap with no flag
    fetch(32'h0000_0006, 0, 0);
    exec(2'd1, 1'b0, 32'hFFFF_FFFC);
    fetch(32'h0000_0007, 0, 0);
    exec(2'd0, 1'b0, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);
    chk("wrap_misalign", 32'(misalign), 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      logic [31:0] w;
      w = $urandom;
      fetch(w, $urandom_range(0, 3), $urandom_range(0, 2));
      for (int h = $urandom_range(0, 2); h > 0; h--) begin
        halt = 1'($urandom_range(0, 1));
        imem_ack = 1'($urandom_range(0, 1));
        step();
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_ir", instruction, exp_ir);
        chk("hold_pc", pc_out, exp_pc);
      end
      exec(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset while waiting for ack at 0x40
    fetch(32'h0000_0008, 0, 0);
    exec(2'd1, 1'b0, 32'h0000_0040);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t6_wait_addr", imem_addr, 32'h0000_0040);
      step();
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
